// File: rtl/carrega_matriz_pkg.sv
// Shared constants for the scalar-multiply ULA stages: matrix geometry,
// element width and the loader state encoding.
package carrega_matriz_pkg;

    localparam int unsigned N_ELEM = 25;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned IDX_W  = $clog2(N_ELEM);
    localparam int unsigned MAT_W  = N_ELEM * ELEM_W;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/carrega_matriz.sv
// Byte-serial loader for the scalar-multiply stage. Collects N_ELEM matrix
// elements and a scalar from a valid/ready stream, then presents the packed
// matrix and scalar downstream and holds them until consumed.
module carrega_matriz
    import carrega_matriz_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_is_scalar,
    input  logic              clear,
    output logic              mat_valid,
    input  logic              mat_ready,
    output logic [MAT_W-1:0]  matriz_a,
    output logic [ELEM_W-1:0] data_escalar,
    output logic [IDX_W-1:0]  elem_count
);

    state_t            state;
    logic              accept;
    logic              accept_elem;
    logic [ELEM_W-1:0] elem_q [N_ELEM];

    // A beat is only taken in LOAD (in_ready), and clear drops it outright.
    assign accept      = in_valid && in_ready && !clear;
    assign accept_elem = accept && !in_is_scalar;

    // Load/hold state machine with registered handshake outputs and counters.
    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every
        // reader sees the pre-edge value; blocking here would create races.
        if (reset) begin
            state        <= ST_LOAD;
            elem_count   <= '0;
            data_escalar <= '0;
            mat_valid    <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (clear) begin
                        elem_count <= '0;
                    end else if (accept) begin
                        if (in_is_scalar) begin
                            data_escalar <= in_data;
                        end else begin
                            elem_count <= elem_count + 1'b1;
                            if (elem_count == IDX_W'(N_ELEM - 1)) begin
                                state     <= ST_FULL;
                                mat_valid <= 1'b1;
                                in_ready  <= 1'b0;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    // clear and in_valid are ignored: a complete matrix is
                    // only released by the downstream handshake or reset.
                    if (mat_ready) begin
                        state      <= ST_LOAD;
                        elem_count <= '0;
                        mat_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    mat_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // One storage byte per element, written when elem_count selects it.
    for (genvar i = 0; i < N_ELEM; i++) begin : g_elem
        logic elem_we;

        assign elem_we = accept_elem && (elem_count == IDX_W'(i));

        // Element register: cleared by reset, loaded on its decoded enable.
        always_ff @(posedge clk) begin
            // NOTE: the matrix storage is reset because its zero value is
            // visible on matriz_a straight after reset, unlike a hidden RAM.
            if (reset) begin
                elem_q[i] <= '0;
            end else if (elem_we) begin
                elem_q[i] <= in_data;
            end
        end

        assign matriz_a[i*ELEM_W +: ELEM_W] = elem_q[i];
    end

endmodule

// File: tb/tb_carrega_matriz.sv
// Self-checking bench for carrega_matriz: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model
// and a scoreboard of completed matrices.
module tb_carrega_matriz;
    import carrega_matriz_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_is_scalar;
    logic              clear;
    logic              mat_valid;
    logic              mat_ready;
    logic [MAT_W-1:0]  matriz_a;
    logic [ELEM_W-1:0] data_escalar;
    logic [IDX_W-1:0]  elem_count;

    carrega_matriz dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_is_scalar (in_is_scalar),
        .clear        (clear),
        .mat_valid    (mat_valid),
        .mat_ready    (mat_ready),
        .matriz_a     (matriz_a),
        .data_escalar (data_escalar),
        .elem_count   (elem_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    bit checking = 1'b0;

    // Behavioural model: a plain byte array, a count and a "full" flag.
    logic [7:0]   m_mat [N_ELEM];
    logic [7:0]   m_scalar;
    int           m_count;
    bit           m_full;
    logic [199:0] sb[$];

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [199:0] pack_model(input int idx, input logic [7:0] v);
        logic [199:0] p;
        for (int k = 0; k < N_ELEM; k++) p[k*8 +: 8] = (k == idx) ? v : m_mat[k];
        return p;
    endfunction

    // Model update on each rising edge from the inputs the bench is driving.
    always @(posedge clk) begin
        if (reset) begin
            m_full   <= 1'b0;
            m_count  <= 0;
            m_scalar <= '0;
            for (int k = 0; k < N_ELEM; k++) m_mat[k] <= '0;
            sb.delete();
        end else if (!m_full) begin
            if (clear) begin
                m_count <= 0;
            end else if (in_valid) begin
                if (in_is_scalar) begin
                    m_scalar <= in_data;
                end else begin
                    m_mat[m_count] <= in_data;
                    m_count        <= m_count + 1;
                    if (m_count == N_ELEM - 1) begin
                        m_full <= 1'b1;
                        sb.push_back(pack_model(m_count, in_data));
                    end
                end
            end
        end else if (mat_ready) begin
            m_full  <= 1'b0;
            m_count <= 0;
        end
    end

    // Compare process: every falling edge, outputs against the model, and
    // each downstream transfer against the scoreboard.
    always @(negedge clk) begin
        if (checking) begin
            check("in_ready",     in_ready,     !m_full);
            check("mat_valid",    mat_valid,    m_full);
            check("elem_count",   elem_count,   m_count);
            check("data_escalar", data_escalar, m_scalar);
            check("matriz_a",     matriz_a,     pack_model(-1, 8'h00));
            if (!reset && m_full && mat_ready) begin
                if (sb.size() == 0) begin
                    check("xfer_unexpected", 1, 0);
                end else begin
                    check("xfer_matrix", matriz_a, sb.pop_front());
                    n_xfer++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_is_scalar = 1'b0;
        in_data      = '0;
        clear        = 1'b0;
        mat_ready    = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic sc);
        in_valid     = 1'b1;
        in_data      = d;
        in_is_scalar = sc;
        tick();
        in_valid     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic handshake();
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
    endtask

    logic [199:0] exp_m;
    int           base;

    initial begin
        idle();
        reset = 1'b1;
        tick();
        checking = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_matriz",    matriz_a,   0);
        check("rst_mat_valid", mat_valid,  0);
        check("rst_in_ready",  in_ready,   1);
        check("rst_count",     elem_count, 0);

        // Scalar 0x03 then elements 0x01..0x19 back to back.
        in_valid = 1'b1;
        in_is_scalar = 1'b1;
        in_data = 8'h03;
        tick();
        for (int i = 0; i < N_ELEM; i++) begin
            in_is_scalar = 1'b0;
            in_data = 8'(i + 1);
            tick();
            if (i == N_ELEM - 2) check("t1_not_yet_valid", mat_valid, 0);
        end
        in_valid = 1'b0;
        check("t1_mat_valid", mat_valid, 1);
        check("t1_lo_byte",   matriz_a[7:0], 8'h01);
        check("t1_hi_byte",   matriz_a[199:192], 8'h19);
        check("t1_scalar",    data_escalar, 8'h03);
        check("t1_count",     elem_count, 25);
        check("t1_in_ready",  in_ready, 0);
        for (int i = 0; i < N_ELEM; i++) exp_m[i*8 +: 8] = 8'(i + 1);

        // Hold in FULL while upstream keeps pushing 0xFF.
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (10) tick();
        in_valid = 1'b0;
        check("t1_hold_matrix", matriz_a, exp_m);
        check("t1_hold_scalar", data_escalar, 8'h03);
        check("t1_hold_count",  elem_count, 25);
        check("t1_hold_ready",  in_ready, 0);
        handshake();
        check("t1_hs_valid", mat_valid, 0);
        check("t1_hs_ready", in_ready, 1);
        check("t1_hs_count", elem_count, 0);

        // Ten elements, then clear together with an eleventh beat.
        for (int i = 0; i < 10; i++) beat(8'(8'hA0 + i), 1'b0);
        in_valid = 1'b1;
        in_data = 8'hEE;
        clear = 1'b1;
        tick();
        in_valid = 1'b0;
        clear = 1'b0;
        check("t2_count",     elem_count, 0);
        check("t2_slot10",    matriz_a[87:80], 8'h0B);
        check("t2_slot9",     matriz_a[79:72], 8'hA9);
        for (int i = 0; i < N_ELEM; i++) beat(8'(8'h40 + i), 1'b0);
        for (int i = 0; i < N_ELEM; i++) exp_m[i*8 +: 8] = 8'(8'h40 + i);
        check("t2_valid",  mat_valid, 1);
        check("t2_matrix", matriz_a, exp_m);
        handshake();

        // Scalar beats 0x05 then 0x07 between elements 3 and 4.
        for (int i = 0; i < 4; i++) beat(8'(8'h60 + i), 1'b0);
        beat(8'h05, 1'b1);
        beat(8'h07, 1'b1);
        check("t3_count", elem_count, 4);
        for (int i = 4; i < N_ELEM; i++) beat(8'(8'h60 + i), 1'b0);
        check("t3_scalar", data_escalar, 8'h07);
        check("t3_elem4",  matriz_a[39:32], 8'h64);
        check("t3_valid",  mat_valid, 1);
        handshake();

        // Reset at elem_count 12, and again while FULL.
        for (int i = 0; i < 12; i++) beat(8'(8'h80 + i), 1'b0);
        check("t4_count12", elem_count, 12);
        do_reset();
        check("t4a_matrix", matriz_a, 0);
        check("t4a_valid",  mat_valid, 0);
        check("t4a_ready",  in_ready, 1);
        for (int i = 0; i < N_ELEM; i++) beat(8'(8'h90 + i), 1'b0);
        check("t4b_full", mat_valid, 1);
        do_reset();
        check("t4b_matrix", matriz_a, 0);
        check("t4b_valid",  mat_valid, 0);
        check("t4b_ready",  in_ready, 1);
        check("t4b_count",  elem_count, 0);
        check("t4b_scalar", data_escalar, 0);

        // Random gaps and downstream delays over 20 matrices.
        base = n_xfer;
        for (int cyc = 0; cyc < 20000 && (n_xfer - base) < 20; cyc++) begin
            in_valid = ($urandom_range(1, 0) == 1);
            in_data  = 8'($urandom);
            if (in_valid) in_is_scalar = ($urandom_range(9, 0) == 0);
            else          in_is_scalar = 1'bx;
            mat_ready = ($urandom_range(1, 0) == 1);
            tick();
        end
        idle();
        check("rand_xfers", n_xfer - base, 20);
        tick();
        if (m_full) handshake();
        tick();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
